// File: rtl/cache_ctrl_burst.sv
// Write-through, no-write-allocate L1 cache controller FSM with multi-beat line
// refill, per-byte valid qualification and a programmable per-beat bus latency.
module cache_ctrl_burst #(
  parameter int LINE_WORDS  = 4,
  parameter int BEAT_W      = 2,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p_strobe,
  input  logic              p_read,
  input  logic              p_fetch,
  input  logic [2:0]        func3,
  input  logic [1:0]        addr_lo,
  input  logic              match,
  input  logic [3:0]        valid,
  output logic              p_ready,
  output logic              cache_write,
  output logic [3:0]        cache_byte_en,
  output logic              cache_data_sel,
  output logic              p_data_sel,
  output logic              p_data_oe,
  output logic              sys_data_oe,
  output logic              sys_strobe,
  output logic              sys_rw,
  output logic [BEAT_W-1:0] sys_beat,
  output logic [1:0]        load_sel,
  output logic              busy
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_REFILL_WAIT,
    S_REFILL_WR,
    S_RESP,
    S_WR_START,
    S_WR_WAIT,
    S_WR_DONE
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  state_t           state, state_next;
  logic [BEAT_W-1:0] beat, beat_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic              wr_hit, wr_hit_next;
  size_t             size;
  logic [3:0]        need;
  logic              hit;

  // Access-size decode; instruction fetches are always whole words.
  always_comb begin
    size = SZ_BYTE;
    if (p_fetch) begin
      size = SZ_WORD;
    end else begin
      case (func3)
        3'd1, 3'd5: size = SZ_HALF;
        3'd2:       size = SZ_WORD;
        default:    size = SZ_BYTE;
      endcase
    end
  end

  always_comb begin
    case (size)
      SZ_BYTE: need = 4'b0001 << addr_lo;
      SZ_HALF: need = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: need = 4'hF;
    endcase
  end

  // Only the byte lanes the access actually touches must be valid.
  assign hit = match & (&(valid | ~need));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      beat   <= '0;
      cnt    <= '0;
      wr_hit <= 1'b0;
    end else begin
      state  <= state_next;
      beat   <= beat_next;
      cnt    <= cnt_next;
      wr_hit <= wr_hit_next;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next     = state;
    beat_next      = beat;
    cnt_next       = cnt;
    wr_hit_next    = wr_hit;
    p_ready        = 1'b0;
    cache_write    = 1'b0;
    cache_byte_en  = 4'h0;
    cache_data_sel = 1'b0;
    p_data_sel     = 1'b0;
    p_data_oe      = 1'b0;
    sys_data_oe    = 1'b0;
    sys_strobe     = 1'b0;
    sys_rw         = 1'b0;
    sys_beat       = '0;

    case (state)
      S_IDLE: begin
        if (p_strobe) state_next = S_LOOKUP;
      end
      S_LOOKUP: begin
        p_data_oe = 1'b1;
        if (p_read) begin
          if (hit) begin
            p_ready    = 1'b1;
            state_next = S_IDLE;
          end else begin
            beat_next  = '0;
            cnt_next   = CNT_LOAD;
            state_next = S_REFILL_WAIT;
          end
        end else begin
          wr_hit_next = hit;
          state_next  = S_WR_START;
        end
      end
      S_REFILL_WAIT: begin
        sys_strobe = 1'b1;
        sys_rw     = 1'b1;
        p_data_oe  = 1'b1;
        sys_beat   = beat;
        if (cnt == '0) state_next = S_REFILL_WR;
        else           cnt_next   = cnt - CNT_W'(1);
      end
      S_REFILL_WR: begin
        sys_strobe     = 1'b1;
        sys_rw         = 1'b1;
        cache_write    = 1'b1;
        cache_byte_en  = 4'hF;
        cache_data_sel = 1'b1;
        sys_beat       = beat;
        if (beat == LAST_BEAT) begin
          state_next = S_RESP;
        end else begin
          beat_next  = beat + BEAT_W'(1);
          cnt_next   = CNT_LOAD;
          state_next = S_REFILL_WAIT;
        end
      end
      S_RESP: begin
        p_ready    = 1'b1;
        p_data_oe  = 1'b1;
        state_next = S_IDLE;
      end
      S_WR_START: begin
        sys_strobe    = 1'b1;
        sys_data_oe   = 1'b1;
        cache_write   = wr_hit;
        cache_byte_en = wr_hit ? need : 4'h0;
        cnt_next      = CNT_LOAD;
        state_next    = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        sys_data_oe = 1'b1;
        if (cnt == '0) state_next = S_WR_DONE;
        else           cnt_next   = cnt - CNT_W'(1);
      end
      S_WR_DONE: begin
        p_ready     = 1'b1;
        sys_data_oe = 1'b1;
        state_next  = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase

    // A completion must never be signalled while reset is being applied.
    if (rst) p_ready = 1'b0;
  end

  assign busy     = (state != S_IDLE);
  assign load_sel = busy ? size : SZ_BYTE;

endmodule

// File: tb/tb_cache_ctrl_burst.sv
// Randomized bench for cache_ctrl_burst: two configurations (4x2 and 8x1) run in
// lockstep and are compared every cycle against a transaction-level timing model.
module tb_cache_ctrl_burst;

  typedef struct packed {
    logic       p_ready;
    logic       cache_write;
    logic [3:0] byte_en;
    logic       cache_data_sel;
    logic       p_data_sel;
    logic       p_data_oe;
    logic       sys_data_oe;
    logic       sys_strobe;
    logic       sys_rw;
    logic [7:0] sys_beat;
    logic [1:0] load_sel;
    logic       busy;
  } out_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       p_strobe, p_read, p_fetch, match;
  logic [2:0] func3;
  logic [1:0] addr_lo;
  logic [3:0] valid;

  logic       a_p_ready, a_cache_write, a_cache_data_sel, a_p_data_sel, a_p_data_oe;
  logic       a_sys_data_oe, a_sys_strobe, a_sys_rw, a_busy;
  logic [3:0] a_cache_byte_en;
  logic [1:0] a_sys_beat, a_load_sel;
  logic       b_p_ready, b_cache_write, b_cache_data_sel, b_p_data_sel, b_p_data_oe;
  logic       b_sys_data_oe, b_sys_strobe, b_sys_rw, b_busy;
  logic [3:0] b_cache_byte_en;
  logic [2:0] b_sys_beat;
  logic [1:0] b_load_sel;

  out_t obs_a, obs_b;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model state per configuration: 0 = LINE_WORDS 4 / WAIT 2, 1 = LINE_WORDS 8 / WAIT 1.
  int         lw_of [2] = '{4, 8};
  int         wc_of [2] = '{2, 1};
  bit         m_busy [2];
  int         m_rel  [2];
  bit         c_read [2];
  bit         c_hit  [2];
  logic [3:0] c_need [2];
  logic [1:0] c_ls   [2];
  int         ready_rel [2];

  always #5 clk = ~clk;

  cache_ctrl_burst u_dut_a (
    .clk(clk), .rst(rst), .p_strobe(p_strobe), .p_read(p_read), .p_fetch(p_fetch),
    .func3(func3), .addr_lo(addr_lo), .match(match), .valid(valid),
    .p_ready(a_p_ready), .cache_write(a_cache_write), .cache_byte_en(a_cache_byte_en),
    .cache_data_sel(a_cache_data_sel), .p_data_sel(a_p_data_sel), .p_data_oe(a_p_data_oe),
    .sys_data_oe(a_sys_data_oe), .sys_strobe(a_sys_strobe), .sys_rw(a_sys_rw),
    .sys_beat(a_sys_beat), .load_sel(a_load_sel), .busy(a_busy)
  );

  cache_ctrl_burst #(.LINE_WORDS(8), .BEAT_W(3), .WAIT_CYCLES(1)) u_dut_b (
    .clk(clk), .rst(rst), .p_strobe(p_strobe), .p_read(p_read), .p_fetch(p_fetch),
    .func3(func3), .addr_lo(addr_lo), .match(match), .valid(valid),
    .p_ready(b_p_ready), .cache_write(b_cache_write), .cache_byte_en(b_cache_byte_en),
    .cache_data_sel(b_cache_data_sel), .p_data_sel(b_p_data_sel), .p_data_oe(b_p_data_oe),
    .sys_data_oe(b_sys_data_oe), .sys_strobe(b_sys_strobe), .sys_rw(b_sys_rw),
    .sys_beat(b_sys_beat), .load_sel(b_load_sel), .busy(b_busy)
  );

  assign obs_a = {a_p_ready, a_cache_write, a_cache_byte_en, a_cache_data_sel, a_p_data_sel,
                  a_p_data_oe, a_sys_data_oe, a_sys_strobe, a_sys_rw, 8'(a_sys_beat),
                  a_load_sel, a_busy};
  assign obs_b = {b_p_ready, b_cache_write, b_cache_byte_en, b_cache_data_sel, b_p_data_sel,
                  b_p_data_oe, b_sys_data_oe, b_sys_strobe, b_sys_rw, 8'(b_sys_beat),
                  b_load_sel, b_busy};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int size_bytes();
    if (p_fetch) return 4;
    case (func3)
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 1;
    endcase
  endfunction

  function automatic logic [3:0] model_need();
    int sz  = size_bytes();
    int off = (sz == 4) ? 0 : (sz == 2) ? (int'(addr_lo) & 2) : int'(addr_lo);
    return 4'(((1 << sz) - 1) << off);
  endfunction

  function automatic int latency(input int k);
    if (c_read[k]) return c_hit[k] ? 1 : 2 + lw_of[k] * (wc_of[k] + 1);
    return 3 + wc_of[k];
  endfunction

  // Expected outputs from the position inside the transaction (cycle m_rel after the strobe edge).
  function automatic out_t model_out(input int k);
    out_t o = '0;
    int   rel = m_rel[k];
    int   lat, wc, j;
    if (!m_busy[k]) return o;
    lat = latency(k);
    wc  = wc_of[k];
    o.busy     = 1'b1;
    o.load_sel = c_ls[k];
    if (rel == 1) begin
      o.p_data_oe = 1'b1;
      o.p_ready   = c_read[k] && c_hit[k] && !rst;
    end else if (c_read[k]) begin
      if (rel == lat) begin
        o.p_ready   = !rst;
        o.p_data_oe = 1'b1;
      end else begin
        j = rel - 2;
        o.sys_strobe = 1'b1;
        o.sys_rw     = 1'b1;
        o.sys_beat   = 8'(j / (wc + 1));
        if (j % (wc + 1) == wc) begin
          o.cache_write    = 1'b1;
          o.byte_en        = 4'hF;
          o.cache_data_sel = 1'b1;
        end else begin
          o.p_data_oe = 1'b1;
        end
      end
    end else begin
      o.sys_data_oe = 1'b1;
      if (rel == 2) begin
        o.sys_strobe  = 1'b1;
        o.cache_write = c_hit[k];
        o.byte_en     = c_hit[k] ? c_need[k] : 4'h0;
      end else if (rel == lat) begin
        o.p_ready = !rst;
      end
    end
    return o;
  endfunction

  // One clock: compare both DUTs mid-cycle, then advance the model at the edge.
  task automatic tick();
    out_t ea, eb;
    int   sz;
    @(negedge clk);
    ea = model_out(0);
    eb = model_out(1);
    check("outs_a", 32'(obs_a), 32'(ea));
    check("outs_b", 32'(obs_b), 32'(eb));
    if (a_p_ready) ready_rel[0] = m_rel[0];
    if (b_p_ready) ready_rel[1] = m_rel[1];
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_busy[k] = 1'b0;
      end else if (!m_busy[k]) begin
        if (p_strobe) begin
          sz        = size_bytes();
          m_busy[k] = 1'b1;
          m_rel[k]  = 1;
          c_read[k] = p_read;
          c_need[k] = model_need();
          c_hit[k]  = match && ((valid & c_need[k]) == c_need[k]);
          c_ls[k]   = (sz == 1) ? 2'd0 : (sz == 2) ? 2'd1 : 2'd2;
        end
      end else if (m_rel[k] == latency(k)) begin
        m_busy[k] = 1'b0;
      end else begin
        m_rel[k]++;
      end
    end
    #1;
    cyc++;
  endtask

  // Issue one request; optionally re-strobe config A in its first idle cycle, and/or
  // pulse reset at loop step rst_at (step n observes transaction cycle n+1).
  task automatic run_txn(input bit rd, input bit fe, input logic [2:0] f3, input logic [1:0] ad,
                         input bit m, input logic [3:0] v, input bit b2b, input int rst_at);
    bit restrobed = 1'b0;
    int n = 0;
    p_read = rd; p_fetch = fe; func3 = f3; addr_lo = ad; match = m; valid = v;
    ready_rel[0] = -1;
    ready_rel[1] = -1;
    p_strobe = 1'b1;
    tick();
    p_strobe = 1'b0;
    while ((m_busy[0] || m_busy[1]) && n < 200) begin
      if (b2b && !restrobed && !m_busy[0]) begin
        p_strobe  = 1'b1;
        restrobed = 1'b1;
      end
      if (rst_at == n) rst = 1'b1;
      tick();
      p_strobe = 1'b0;
      rst      = 1'b0;
      n++;
    end
    if (n >= 200) check("txn_timeout", 32'(n), 32'd0);
    tick();
  endtask

  initial begin
    rst = 1'b1; p_strobe = 1'b0; p_read = 1'b0; p_fetch = 1'b0;
    func3 = 3'd0; addr_lo = 2'd0; match = 1'b0; valid = 4'h0;
    m_busy = '{1'b0, 1'b0};
    m_rel  = '{0, 0};
    @(posedge clk);
    #1;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Read hit, word.
    run_txn(1, 0, 3'd2, 2'd0, 1, 4'hF, 0, -1);
    check("lat_hit_a", 32'(ready_rel[0]), 32'd1);
    check("lat_hit_b", 32'(ready_rel[1]), 32'd1);
    // Half-word in upper lanes: valid only where needed is still a hit.
    run_txn(1, 0, 3'd1, 2'd2, 1, 4'b1100, 0, -1);
    check("lat_partial_hit", 32'(ready_rel[0]), 32'd1);
    // Same half-word with the wrong lanes valid: full refill.
    run_txn(1, 0, 3'd1, 2'd2, 1, 4'b0011, 0, -1);
    check("lat_miss_a", 32'(ready_rel[0]), 32'd14);
    check("lat_miss_b", 32'(ready_rel[1]), 32'd18);
    // Store hit on byte 3 and store miss.
    run_txn(0, 0, 3'd0, 2'd3, 1, 4'hF, 0, -1);
    check("lat_store_hit_a", 32'(ready_rel[0]), 32'd5);
    check("lat_store_hit_b", 32'(ready_rel[1]), 32'd4);
    run_txn(0, 0, 3'd0, 2'd3, 0, 4'hF, 0, -1);
    check("lat_store_miss", 32'(ready_rel[0]), 32'd5);
    // Fetch forces a word access: one valid byte is a miss.
    run_txn(1, 1, 3'd0, 2'd0, 1, 4'b0001, 0, -1);
    check("lat_fetch_miss", 32'(ready_rel[0]), 32'd14);
    // Reset during the first wait cycle of beat 2 (transaction cycle 8), then a clean refill.
    run_txn(1, 0, 3'd2, 2'd0, 0, 4'hF, 0, 7);
    check("rst_no_ready", 32'(ready_rel[0]), 32'hFFFF_FFFF);
    run_txn(1, 0, 3'd2, 2'd0, 0, 4'hF, 0, -1);
    check("lat_after_rst", 32'(ready_rel[0]), 32'd14);
    // Back-to-back read hits.
    run_txn(1, 0, 3'd2, 2'd0, 1, 4'hF, 1, -1);

    for (int t = 0; t < 150; t++) begin
      logic [2:0] f3;
      int         rsel;
      f3   = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 5));
      rsel = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : -1;
      run_txn(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), f3,
              2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
              ($urandom_range(0, 4) == 0), rsel);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_ctrl_burst.md
Name: cache_ctrl_burst

Overview:
- Parametrised next-generation L1 data/instruction cache controller FSM; sits between processor pipeline stall logic and system bus interface.
- Write-through, no-write-allocate.
- Per-byte valid qualification; multi-beat line refill (LINE_WORDS beats); programmable per-beat memory latency via internal wait counter.
- Drives cache array write strobes/byte enables, data-path muxes, bus tri-state enables.

Parameters:
- LINE_WORDS, 4, words per cache line, refilled per miss (power of 2, >=1)
- BEAT_W, 2, width of beat index, = max(1, log2(LINE_WORDS))
- WAIT_CYCLES, 2, system-bus cycles per beat (>=1)

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous active-high reset
- p_strobe  in  1  processor request; sampled in IDLE only
- p_read  in  1  1=load/fetch, 0=store
- p_fetch  in  1  instruction fetch; forces word access
- func3  in  3  load/store size code (0 B, 1 H, 2 W, 4 BU, 5 HU)
- addr_lo  in  2  byte offset within word
- match  in  1  tag compare result
- valid  in  4  per-byte valid bits of addressed word
- p_ready  out  1  request complete, release stall
- cache_write  out  1  cache array write strobe
- cache_byte_en  out  4  byte lanes written
- cache_data_sel  out  1  0=processor data, 1=system data into cache
- p_data_sel  out  1  0=cache to processor, 1=system bus to processor
- p_data_oe  out  1  drive processor data bus
- sys_data_oe  out  1  drive system data bus (stores)
- sys_strobe  out  1  system bus request
- sys_rw  out  1  1=read, 0=write
- sys_beat  out  BEAT_W  word index of current refill beat
- load_sel  out  2  0 byte, 1 half, 2 word
- busy  out  1  FSM not in IDLE

Behaviour:
- Size decode (combinational): p_fetch=1 -> word. Else func3 0/4 -> byte, 1/5 -> half, 2 -> word, others -> byte. load_sel follows decode.
- need mask: byte = 1<<addr_lo; half = 2'b11<<{addr_lo[1],0} (addr_lo[0] ignored); word = 4'hF.
- hit = match & &(valid | ~need).
- States: IDLE, LOOKUP, REFILL_WAIT, REFILL_WR, RESP, WR_START, WR_WAIT, WR_DONE.
- IDLE: p_strobe -> LOOKUP. All outputs 0.
- LOOKUP: p_data_oe=1.
  - Read: hit -> p_ready=1 (combinational), -> IDLE. Miss -> REFILL_WAIT; beat=0; wait counter=WAIT_CYCLES-1.
  - Write: latch hit into wr_hit; -> WR_START.
- REFILL_WAIT: sys_strobe=1, sys_rw=1, p_data_oe=1. Counter decrements; at 0 -> REFILL_WR. Occupies exactly WAIT_CYCLES cycles.
- REFILL_WR: sys_strobe=1, sys_rw=1, cache_write=1, cache_byte_en=4'hF, cache_data_sel=1.
  - beat==LINE_WORDS-1 -> RESP.
  - Else beat+1, reload counter, -> REFILL_WAIT.
- RESP: p_ready=1, p_data_oe=1, p_data_sel=0 (data from refilled cache); -> IDLE.
- WR_START: sys_strobe=1, sys_rw=0, sys_data_oe=1; counter loaded WAIT_CYCLES-1.
  - cache_write=wr_hit, cache_byte_en=need when wr_hit else 0, cache_data_sel=0.
  - -> WR_WAIT.
- WR_WAIT: sys_data_oe=1; counter at 0 -> WR_DONE.
- WR_DONE: p_ready=1, sys_data_oe=1; -> IDLE.
- sys_beat = beat register in refill states, 0 elsewhere. busy = (state!=IDLE).
- Latency from strobe-sample edge:
  - read hit: p_ready 1 cycle.
  - read miss: p_ready 2+LINE_WORDS*(WAIT_CYCLES+1) cycles; default 14.
  - write: 3+WAIT_CYCLES cycles; default 5.
- p_strobe outside IDLE ignored; back-to-back request accepted in the IDLE cycle following the p_ready cycle.
- Processor holds func3/addr_lo/p_read/p_fetch stable until p_ready.
- rst sampled high in any state -> IDLE next edge; beat, counter, wr_hit cleared; all outputs 0 at/after that edge. p_ready low during reset.
- WAIT_CYCLES=1: each REFILL_WAIT/WR_WAIT lasts one cycle. LINE_WORDS=1: single beat, beat never increments.

Test Plan:
- Read hit: func3=2, match=1, valid=4'hF, strobe cycle 0 -> p_ready=1 in cycle 1 only; no sys_strobe; busy low cycle 2.
- Partial-valid read: func3=1, addr_lo=2, valid=4'b1100, match=1 -> hit, p_ready cycle 1. Same with valid=4'b0011 -> miss; cache_write pulses in cycles 4,7,10,13 with sys_beat 0,1,2,3; p_ready cycle 14.
- Store hit: func3=0, addr_lo=3, hit -> WR_START cycle 2: cache_write=1, cache_byte_en=4'b1000, sys_rw=0; p_ready cycle 5.
- Store miss: match=0 -> cache_write stays 0 throughout; sys_strobe cycle 2; p_ready cycle 5.
- Fetch override: p_fetch=1, func3=0, valid=4'b0001, match=1 -> treated as word: miss, load_sel=2.
- Reset mid-refill: rst high in REFILL_WAIT of beat 2 -> next cycle all outputs 0, busy=0; new strobe runs full refill from beat 0.
- Parameter sweep: LINE_WORDS=8, WAIT_CYCLES=1 -> read miss p_ready at cycle 18.
